// File: rtl/readout_pkg.sv
// -----------------------------------------------------------------------------
// readout_pkg
// Shared types and helpers for the period readout serializer.
//   readout_mode_t  : which measurement bus is snapshotted (PERIOD, TIME_HIGH,
//                     TIME_LOW, TEST pattern)
//   readout_state_t : readout FSM states (IDLE, SHIFT)
//   slice_lsb()     : LSB position of a word inside a flattened channel bus
// -----------------------------------------------------------------------------
package readout_pkg;

  typedef enum logic [1:0] {
    MODE_PERIOD    = 2'd0,
    MODE_TIME_HIGH = 2'd1,
    MODE_TIME_LOW  = 2'd2,
    MODE_TEST      = 2'd3
  } readout_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } readout_state_t;

  // Flattened buses pack word n at [n*width +: width]
  function automatic int slice_lsb(input int index, input int width);
    return index * width;
  endfunction

endpackage

// File: rtl/lane_serializer.sv
// -----------------------------------------------------------------------------
// lane_serializer
// Holds the snapshot of one output lane (WORDS words of WIDTH bits) and
// shifts it out MSB-first, word 0 first.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : capture i_data (takes priority over i_shift)
//   i_shift        : advance one bit
//   i_data         : lane words, word k at [k*WIDTH +: WIDTH]
//   o_msb          : current serial bit (register output)
// -----------------------------------------------------------------------------
module lane_serializer
  import readout_pkg::*;
#(
  parameter int WORDS = 8,
  parameter int WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic                   i_shift,
  input  logic [WORDS*WIDTH-1:0] i_data,
  output logic                   o_msb
);

  localparam int BITS = WORDS * WIDTH;

  logic [BITS-1:0] w_load_vec;
  logic [BITS-1:0] r_shreg;

  // Reverse word order so word 0 sits at the top of the shift register and
  // leaves first; bits inside each word stay MSB-high.
  for (genvar k = 0; k < WORDS; k++) begin : g_order
    assign w_load_vec[slice_lsb(WORDS-1-k, WIDTH) +: WIDTH] =
      i_data[slice_lsb(k, WIDTH) +: WIDTH];
  end

  // Zero fill on shift: once the last bit has left, the lane idles at 0
  // without needing a separate clear strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= w_load_vec;
    end else if (i_shift) begin
      r_shreg <= {r_shreg[BITS-2:0], 1'b0};
    end
  end

  assign o_msb = r_shreg[BITS-1];

endmodule

// File: rtl/period_readout_serializer.sv
// -----------------------------------------------------------------------------
// period_readout_serializer
// Snapshots one measurement (selected by MODE) from all channels and streams
// it out MSB-first over LANES serial pins with framing strobes.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   TIME_HIGH/TIME_LOW/
//   PERIOD              : flattened channel buses, channel i at
//                         [i*COUNTER_BITS +: COUNTER_BITS]
//   MODE                : 0 PERIOD, 1 TIME_HIGH, 2 TIME_LOW, 3 TEST (index)
//   START               : level request for a frame (ignored while busy)
//   CONTINUOUS          : chain frames back-to-back while high
//   LANE_OUT            : serial data, lane l carries channels l*WPL..
//   FRAME_VALID         : LANE_OUT carries frame data
//   WORD_START          : current bit is the MSB of a word
//   BUSY                : frame in progress
//   DONE                : one-cycle pulse after the last bit of a frame
// All outputs are registered.
// -----------------------------------------------------------------------------
module period_readout_serializer
  import readout_pkg::*;
#(
  parameter int CHANNELS     = 64,
  parameter int COUNTER_BITS = 16,
  parameter int LANES        = 8
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic [CHANNELS*COUNTER_BITS-1:0] TIME_HIGH,
  input  logic [CHANNELS*COUNTER_BITS-1:0] TIME_LOW,
  input  logic [CHANNELS*COUNTER_BITS-1:0] PERIOD,
  input  logic [1:0]                       MODE,
  input  logic                             START,
  input  logic                             CONTINUOUS,
  output logic [LANES-1:0]                 LANE_OUT,
  output logic                             FRAME_VALID,
  output logic                             WORD_START,
  output logic                             BUSY,
  output logic                             DONE
);

  localparam int WPL    = CHANNELS / LANES;
  localparam int BUS_W  = CHANNELS * COUNTER_BITS;
  localparam int BIT_W  = (COUNTER_BITS > 1) ? $clog2(COUNTER_BITS) : 1;
  localparam int WORD_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(COUNTER_BITS - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WPL - 1);

  if (CHANNELS % LANES != 0) begin : g_bad_lanes
    $error("CHANNELS must be a multiple of LANES");
  end
  if (COUNTER_BITS < 2) begin : g_bad_width
    $error("COUNTER_BITS must be at least 2");
  end

  readout_state_t    r_state;
  readout_state_t    w_next_state;
  logic [BIT_W-1:0]  r_bit;
  logic [WORD_W-1:0] r_word;
  logic              r_frame_valid;
  logic              r_word_start;
  logic              r_busy;
  logic              r_done;
  logic              w_load;
  logic              w_shift;
  logic              w_last;
  logic              w_done;
  logic [BUS_W-1:0]  w_test;
  logic [BUS_W-1:0]  w_src;

  // TEST pattern: each word carries its own channel index
  for (genvar i = 0; i < CHANNELS; i++) begin : g_test
    assign w_test[slice_lsb(i, COUNTER_BITS) +: COUNTER_BITS] = COUNTER_BITS'(i);
  end

  // Source select; only consumed on w_load, so MODE matters only at snapshot
  always_comb begin
    w_src = PERIOD;
    case (readout_mode_t'(MODE))
      MODE_PERIOD:    w_src = PERIOD;
      MODE_TIME_HIGH: w_src = TIME_HIGH;
      MODE_TIME_LOW:  w_src = TIME_LOW;
      MODE_TEST:      w_src = w_test;
      default:        w_src = PERIOD;
    endcase
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_serializer #(
      .WORDS (WPL),
      .WIDTH (COUNTER_BITS)
    ) u_lane (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (w_src[slice_lsb(l*WPL, COUNTER_BITS) +: WPL*COUNTER_BITS]),
      .o_msb   (LANE_OUT[l])
    );
  end

  // Next-state logic. A last bit with CONTINUOUS reloads in place so the next
  // frame follows with no gap.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_last       = (r_word == WORD_LAST) && (r_bit == '0);
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_load       = 1'b1;
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (w_last) begin
          w_done = 1'b1;
          if (CONTINUOUS) begin
            w_load = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
    endcase
  end

  // State, bit/word counters and registered strobes. Counters return to zero
  // at the end of a frame so the idle state matches the reset state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ST_IDLE;
      r_bit         <= '0;
      r_word        <= '0;
      r_frame_valid <= 1'b0;
      r_word_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_bit  <= BIT_LAST;
        r_word <= '0;
      end else if (w_shift) begin
        if (w_last) begin
          r_bit  <= '0;
          r_word <= '0;
        end else if (r_bit == '0) begin
          r_bit  <= BIT_LAST;
          r_word <= r_word + WORD_W'(1);
        end else begin
          r_bit <= r_bit - BIT_W'(1);
        end
      end
      r_busy        <= (w_next_state == ST_SHIFT);
      r_frame_valid <= (w_next_state == ST_SHIFT);
      r_word_start  <= w_load | (w_shift & (r_bit == '0) & ~w_last);
      r_done        <= w_done;
    end
  end

  assign FRAME_VALID = r_frame_valid;
  assign WORD_START  = r_word_start;
  assign BUSY        = r_busy;
  assign DONE        = r_done;

endmodule

// File: tb/tb_period_readout_serializer.sv
// -----------------------------------------------------------------------------
// tb_period_readout_serializer
// Two instances: a small TEST-mode configuration driven from a vector table,
// and the default configuration exercised with hand-written frame sequences.
// -----------------------------------------------------------------------------
module tb_period_readout_serializer;

  localparam int CH     = 64;
  localparam int CB     = 16;
  localparam int LN     = 8;
  localparam int WPL    = CH / LN;
  localparam int FLEN   = WPL * CB;
  localparam int S_CH   = 8;
  localparam int S_CB   = 4;
  localparam int S_LN   = 2;
  localparam int S_VECS = 19;

  logic clk = 1'b0;
  logic rstN;

  logic [CH*CB-1:0] timeHigh;
  logic [CH*CB-1:0] timeLow;
  logic [CH*CB-1:0] period;
  logic [1:0]       mode;
  logic             start;
  logic             continuous;
  logic [LN-1:0]    laneOut;
  logic             frameValid;
  logic             wordStart;
  logic             busy;
  logic             done;

  logic [S_CH*S_CB-1:0] sTimeHigh;
  logic [S_CH*S_CB-1:0] sTimeLow;
  logic [S_CH*S_CB-1:0] sPeriod;
  logic [1:0]           sMode;
  logic                 sStart;
  logic                 sContinuous;
  logic [S_LN-1:0]      sLaneOut;
  logic                 sFrameValid;
  logic                 sWordStart;
  logic                 sBusy;
  logic                 sDone;

  int checks = 0;
  int errors = 0;
  int fvCount;
  int wsErrors;

  logic [LN-1:0] frameBits [FLEN];
  logic [CB-1:0] expWord [CH];

  // expOut packs {laneOut[1:0], frameValid, wordStart, busy, done}
  typedef struct packed {
    logic       start;
    logic [1:0] mode;
    logic [5:0] expOut;
  } vec_t;
  vec_t vecs [S_VECS];

  // 100 MHz clock
  always #5 clk = ~clk;

  period_readout_serializer #(
    .CHANNELS     (CH),
    .COUNTER_BITS (CB),
    .LANES        (LN)
  ) u_dut (
    .CLK         (clk),
    .RST_N       (rstN),
    .TIME_HIGH   (timeHigh),
    .TIME_LOW    (timeLow),
    .PERIOD      (period),
    .MODE        (mode),
    .START       (start),
    .CONTINUOUS  (continuous),
    .LANE_OUT    (laneOut),
    .FRAME_VALID (frameValid),
    .WORD_START  (wordStart),
    .BUSY        (busy),
    .DONE        (done)
  );

  period_readout_serializer #(
    .CHANNELS     (S_CH),
    .COUNTER_BITS (S_CB),
    .LANES        (S_LN)
  ) u_small (
    .CLK         (clk),
    .RST_N       (rstN),
    .TIME_HIGH   (sTimeHigh),
    .TIME_LOW    (sTimeLow),
    .PERIOD      (sPeriod),
    .MODE        (sMode),
    .START       (sStart),
    .CONTINUOUS  (sContinuous),
    .LANE_OUT    (sLaneOut),
    .FRAME_VALID (sFrameValid),
    .WORD_START  (sWordStart),
    .BUSY        (sBusy),
    .DONE        (sDone)
  );

  // One comparison: counts it, reports a mismatch with both values
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one table row onto the small instance
  task automatic applyStimulus(input vec_t v);
    sStart = v.start;
    sMode  = v.mode;
  endtask

  // Rebuild a word from captured lane bits, MSB first
  function automatic logic [CB-1:0] getWord(input int lane, input int word);
    logic [CB-1:0] w;
    w = '0;
    for (int b = 0; b < CB; b++) w = {w[CB-2:0], frameBits[word*CB + b][lane]};
    return w;
  endfunction

  task automatic setPeriodBase(input logic [15:0] base);
    for (int i = 0; i < CH; i++) period[i*CB +: CB] = base + 16'(i);
  endtask

  task automatic setExpectBase(input logic [15:0] base);
    for (int i = 0; i < CH; i++) expWord[i] = base + 16'(i);
  endtask

  // Capture one frame of the default instance starting at the current
  // negedge. perturb selects what the bench disturbs mid-frame:
  // 1 randomise TIME_HIGH/TIME_LOW, 2 switch MODE to PERIOD at cycle 40,
  // 3 pulse START at cycle 50, 4 load a new PERIOD base at cycle 10,
  // 5 as 4 and drop CONTINUOUS.
  task automatic captureFrame(input int perturb, input logic [15:0] newBase);
    int waitCycles;
    waitCycles = 0;
    fvCount    = 0;
    wsErrors   = 0;
    while (frameValid !== 1'b1 && waitCycles < 8) begin
      @(negedge clk);
      waitCycles++;
    end
    if (frameValid !== 1'b1) begin
      checkOutput("frameStartTimeout", {63'd0, frameValid}, 64'd1);
      return;
    end
    for (int c = 0; c < FLEN; c++) begin
      frameBits[c] = laneOut;
      if (frameValid === 1'b1) fvCount++;
      if (wordStart !== ((c % CB) == 0)) wsErrors++;
      case (perturb)
        1: begin
          for (int i = 0; i < CH; i++) begin
            timeHigh[i*CB +: CB] = 16'($urandom);
            timeLow[i*CB +: CB]  = 16'($urandom);
          end
        end
        2: if (c == 40) mode = 2'd0;
        3: begin
          if (c == 50) start = 1'b1;
          else if (c == 51) start = 1'b0;
        end
        4: if (c == 10) setPeriodBase(newBase);
        5: begin
          if (c == 10) begin
            setPeriodBase(newBase);
            continuous = 1'b0;
          end
        end
        default: ;
      endcase
      @(negedge clk);
    end
  endtask

  // Compare a captured frame against expWord plus its framing
  task automatic checkFrameWords(input string tag);
    int bad;
    bad = 0;
    for (int ch = 0; ch < CH; ch++)
      if (getWord(ch / WPL, ch % WPL) !== expWord[ch]) bad++;
    checkOutput({tag, "_badWords"}, 64'(bad), 64'd0);
    checkOutput({tag, "_fvCycles"}, 64'(fvCount), 64'(FLEN));
    checkOutput({tag, "_wordStart"}, 64'(wsErrors), 64'd0);
  endtask

  // Hard stop if something wedges the sequence below
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    logic [15:0] lane0Bits;
    logic [15:0] lane1Bits;
    int idleFv;

    rstN        = 1'b0;
    timeHigh    = '0;
    timeLow     = '0;
    period      = '0;
    mode        = 2'd0;
    start       = 1'b0;
    continuous  = 1'b0;
    sTimeHigh   = '0;
    sTimeLow    = '0;
    sPeriod     = '0;
    sMode       = 2'd0;
    sStart      = 1'b0;
    sContinuous = 1'b0;

    // Small TEST-mode frame: lane0 = words 0..3, lane1 = words 4..7
    lane0Bits = 16'h0123;
    lane1Bits = 16'h4567;
    vecs[0].start  = 1'b1;
    vecs[0].mode   = 2'd3;
    vecs[0].expOut = 6'b000000;
    for (int k = 0; k < 16; k++) begin
      vecs[k+1].start  = 1'b0;
      vecs[k+1].mode   = 2'd3;
      vecs[k+1].expOut = {lane1Bits[15-k], lane0Bits[15-k], 1'b1,
                          ((k % 4) == 0), 1'b1, 1'b0};
    end
    vecs[17].start  = 1'b0;
    vecs[17].mode   = 2'd3;
    vecs[17].expOut = 6'b000001;
    vecs[18].start  = 1'b0;
    vecs[18].mode   = 2'd3;
    vecs[18].expOut = 6'b000000;

    repeat (2) @(negedge clk);
    checkOutput("resetOutputs", {55'd0, laneOut, frameValid, wordStart, busy, done}, 64'd0);
    rstN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < S_VECS; i++) begin
      checkOutput($sformatf("small[%0d]", i),
                  {58'd0, sLaneOut, sFrameValid, sWordStart, sBusy, sDone},
                  {58'd0, vecs[i].expOut});
      applyStimulus(vecs[i]);
      @(negedge clk);
    end

    // PERIOD frame while TIME_HIGH/TIME_LOW churn
    setPeriodBase(16'hA000);
    setExpectBase(16'hA000);
    mode  = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    captureFrame(1, 16'h0000);
    checkFrameWords("period");
    checkOutput("periodLane3Word2", 64'(getWord(3, 2)), 64'h0000_0000_0000_A01A);
    checkOutput("periodDoneCycle", {53'd0, frameValid, busy, laneOut, done},
                {53'd0, 1'b0, 1'b0, 8'h00, 1'b1});
    @(negedge clk);
    checkOutput("periodDoneOnePulse", {63'd0, done}, 64'd0);

    // TIME_HIGH frame with MODE changed mid-frame, then TIME_LOW frame
    // started on the DONE cycle
    for (int i = 0; i < CH; i++) begin
      timeHigh[i*CB +: CB] = 16'hB000 + 16'(i * 3);
      timeLow[i*CB +: CB]  = 16'h5A00 + 16'(i);
      expWord[i]           = 16'hB000 + 16'(i * 3);
    end
    mode  = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    captureFrame(2, 16'h0000);
    checkFrameWords("timeHigh");
    checkOutput("timeHighDone", {63'd0, done}, 64'd1);
    mode  = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < CH; i++) expWord[i] = 16'h5A00 + 16'(i);
    captureFrame(0, 16'h0000);
    checkFrameWords("timeLow");

    // START pulse mid-frame must not restart or queue a frame
    mode = 2'd0;
    setExpectBase(16'hA000);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    captureFrame(3, 16'h0000);
    checkFrameWords("busyStart");
    checkOutput("busyStartDone", {63'd0, done}, 64'd1);
    idleFv = 0;
    repeat (5) begin
      @(negedge clk);
      if (frameValid !== 1'b0 || busy !== 1'b0) idleFv++;
    end
    checkOutput("noExtraFrame", 64'(idleFv), 64'd0);

    // Held START: one idle cycle between frames
    start = 1'b1;
    @(negedge clk);
    captureFrame(0, 16'h0000);
    checkOutput("heldDoneCycle", {62'd0, frameValid, done}, 64'd1);
    @(negedge clk);
    checkOutput("heldRestart", {61'd0, frameValid, wordStart, busy}, 64'd7);
    start = 1'b0;
    captureFrame(0, 16'h0000);
    checkFrameWords("heldSecond");

    // Continuous: three gapless frames, each with its own snapshot
    @(negedge clk);
    continuous = 1'b1;
    setPeriodBase(16'hA000);
    setExpectBase(16'hA000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    captureFrame(4, 16'hD000);
    checkFrameWords("cont1");
    checkOutput("cont1Join", {61'd0, frameValid, wordStart, done}, 64'd7);
    setExpectBase(16'hD000);
    captureFrame(4, 16'hE000);
    checkFrameWords("cont2");
    checkOutput("cont2Join", {61'd0, frameValid, wordStart, done}, 64'd7);
    setExpectBase(16'hE000);
    captureFrame(5, 16'hF000);
    checkFrameWords("cont3");
    checkOutput("cont3End", {61'd0, frameValid, busy, done}, 64'd1);

    // Reset asserted between edges at frame cycle 7
    @(negedge clk);
    setPeriodBase(16'h1234);
    setExpectBase(16'h1234);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("preResetBusy", {63'd0, frameValid}, 64'd1);
    #2 rstN = 1'b0;
    #1 checkOutput("resetAsync", {55'd0, laneOut, frameValid, wordStart, busy, done}, 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    idleFv = 0;
    repeat (3) begin
      @(negedge clk);
      if ({laneOut, frameValid, wordStart, busy, done} !== '0) idleFv++;
    end
    checkOutput("idleAfterReset", 64'(idleFv), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    captureFrame(0, 16'h0000);
    checkFrameWords("afterReset");
    checkOutput("afterResetDone", {63'd0, done}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
